// File: rtl/hrm_iobox.sv
// Multi-channel first-word-fall-through FIFO box with a combinational dump port.
// Define HRM_IOBOX_FILL_EN to drive o_fill with the occupancy of i_rd_ch.
module hrm_iobox #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LGFLEN = 5,
  parameter int unsigned NCH    = 2,
  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [CHW-1:0]    i_wr_ch,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_rd,
  input  logic [CHW-1:0]    i_rd_ch,
  output logic [WIDTH-1:0]  o_data,
  output logic [NCH-1:0]    o_empty_n,
  output logic [NCH-1:0]    o_full,
  output logic [NCH-1:0]    o_err,
  output logic [LGFLEN:0]   o_fill,
  input  logic [CHW-1:0]    i_dmp_ch,
  input  logic [LGFLEN-1:0] i_dmp_pos,
  output logic [WIDTH-1:0]  o_dmp_data,
  output logic              o_dmp_valid
);

  localparam int unsigned DEPTH = 2 ** LGFLEN;
  localparam int unsigned CW    = LGFLEN + 1;

  logic [WIDTH-1:0]  mem_q   [NCH][DEPTH];
  logic [LGFLEN-1:0] rdptr_q [NCH];
  logic [LGFLEN-1:0] rdptr_d [NCH];
  logic [LGFLEN-1:0] wrptr_q [NCH];
  logic [LGFLEN-1:0] wrptr_d [NCH];
  logic [CW-1:0]     cnt_q   [NCH];
  logic [CW-1:0]     cnt_d   [NCH];
  logic [NCH-1:0]    err_q, err_d;
  logic [NCH-1:0]    push_c, pop_c, wr_ok_c, rd_ok_c;

  // Per-channel pointer/count update; a pop on a full channel frees the slot for a same-cycle push.
  always_comb begin
    rdptr_d = rdptr_q;
    wrptr_d = wrptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_c  = '0;
    pop_c   = '0;
    wr_ok_c = '0;
    rd_ok_c = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      push_c[c]  = i_wr && (i_wr_ch == CHW'(c));
      pop_c[c]   = i_rd && (i_rd_ch == CHW'(c));
      rd_ok_c[c] = pop_c[c] && (cnt_q[c] != '0);
      wr_ok_c[c] = push_c[c] && ((cnt_q[c] != CW'(DEPTH)) || rd_ok_c[c]);
      if (i_clr) begin
        rdptr_d[c] = '0;
        wrptr_d[c] = '0;
        cnt_d[c]   = '0;
        err_d[c]   = 1'b0;
      end else begin
        if (wr_ok_c[c]) wrptr_d[c] = wrptr_q[c] + LGFLEN'(1);
        if (rd_ok_c[c]) rdptr_d[c] = rdptr_q[c] + LGFLEN'(1);
        cnt_d[c] = cnt_q[c] + CW'(wr_ok_c[c]) - CW'(rd_ok_c[c]);
        if ((pop_c[c] && !rd_ok_c[c]) || (push_c[c] && !wr_ok_c[c])) err_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        rdptr_q[c] <= '0;
        wrptr_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      err_q <= '0;
    end else begin
      rdptr_q <= rdptr_d;
      wrptr_q <= wrptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (wr_ok_c[c] && !i_clr) mem_q[c][wrptr_q[c]] <= i_data;
    end
  end

  // Head, flags and dump view, all decoded from registered state.
  always_comb begin
    o_data      = '0;
    o_dmp_data  = '0;
    o_dmp_valid = 1'b0;
    o_empty_n   = '0;
    o_full      = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      o_empty_n[c] = (cnt_q[c] != '0);
      o_full[c]    = (cnt_q[c] == CW'(DEPTH));
      if ((i_rd_ch == CHW'(c)) && (cnt_q[c] != '0)) o_data = mem_q[c][rdptr_q[c]];
      if ((i_dmp_ch == CHW'(c)) && ({1'b0, i_dmp_pos} < cnt_q[c])) begin
        o_dmp_valid = 1'b1;
        o_dmp_data  = mem_q[c][LGFLEN'(rdptr_q[c] + i_dmp_pos)];
      end
    end
  end

  assign o_err = err_q;

`ifdef HRM_IOBOX_FILL_EN
  always_comb begin
    o_fill = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (i_rd_ch == CHW'(c)) o_fill = cnt_q[c];
    end
  end
`else
  assign o_fill = '0;
`endif

endmodule

// File: tb/tb_hrm_iobox.sv
// Self-checking bench for hrm_iobox: directed scenarios plus random traffic
// compared against a queue-based model of each channel.
module tb_hrm_iobox;

  localparam int D = 32;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_clr, i_wr, i_rd;
  logic [0:0] i_wr_ch, i_rd_ch, i_dmp_ch;
  logic [7:0] i_data;
  logic [4:0] i_dmp_pos;
  logic [7:0] o_data, o_dmp_data;
  logic [1:0] o_empty_n, o_full, o_err;
  logic [5:0] o_fill;
  logic       o_dmp_valid;

  hrm_iobox dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_wr(i_wr), .i_wr_ch(i_wr_ch),
    .i_data(i_data), .i_rd(i_rd), .i_rd_ch(i_rd_ch), .o_data(o_data),
    .o_empty_n(o_empty_n), .o_full(o_full), .o_err(o_err), .o_fill(o_fill),
    .i_dmp_ch(i_dmp_ch), .i_dmp_pos(i_dmp_pos), .o_dmp_data(o_dmp_data),
    .o_dmp_valid(o_dmp_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] mq [2][$];
  logic [1:0] merr;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_outs();
    int rc, dc, dp;
    logic [7:0] ed, edd;
    logic [1:0] een, efu;
    logic       edv;
    logic [5:0] efill;
    rc = int'(i_rd_ch);
    dc = int'(i_dmp_ch);
    dp = int'(i_dmp_pos);
    ed = 8'h00;
    if (mq[rc].size() > 0) ed = mq[rc][0];
    for (int c = 0; c < 2; c++) begin
      een[c] = (mq[c].size() != 0);
      efu[c] = (mq[c].size() == D);
    end
    edv = (dp < mq[dc].size());
    edd = 8'h00;
    if (edv) edd = mq[dc][dp];
`ifdef HRM_IOBOX_FILL_EN
    efill = 6'(mq[rc].size());
`else
    efill = 6'd0;
`endif
    chk("o_data", 32'(o_data), 32'(ed));
    chk("o_empty_n", 32'(o_empty_n), 32'(een));
    chk("o_full", 32'(o_full), 32'(efu));
    chk("o_err", 32'(o_err), 32'(merr));
    chk("o_fill", 32'(o_fill), 32'(efill));
    chk("o_dmp_valid", 32'(o_dmp_valid), 32'(edv));
    chk("o_dmp_data", 32'(o_dmp_data), 32'(edd));
  endtask

  task automatic model_update(input logic wr, input int wch, input logic [7:0] d,
                              input logic rd, input int rch, input logic clr);
    int  s;
    logic push, pop, do_pop, do_push;
    if (clr) begin
      for (int c = 0; c < 2; c++) mq[c].delete();
      merr = '0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      s       = mq[c].size();
      push    = wr && (wch == c);
      pop     = rd && (rch == c);
      do_pop  = pop && (s > 0);
      do_push = push && ((s < D) || do_pop);
      if ((pop && !do_pop) || (push && !do_push)) merr[c] = 1'b1;
      if (do_pop) void'(mq[c].pop_front());
      if (do_push) mq[c].push_back(d);
    end
  endtask

  // One clock: apply inputs, check pre-edge outputs, advance model at the edge.
  task automatic step(input logic wr, input int wch, input logic [7:0] d,
                      input logic rd, input int rch, input logic clr);
    i_wr = wr; i_wr_ch = 1'(wch); i_data = d;
    i_rd = rd; i_rd_ch = 1'(rch); i_clr = clr;
    i_dmp_ch = 1'($urandom); i_dmp_pos = 5'($urandom);
    #1 check_outs();
    @(posedge clk);
    model_update(wr, wch, d, rd, rch, clr);
    #1;
  endtask

  task automatic peek(input int rch, input int dch, input int dpos);
    i_wr = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
    i_rd_ch = 1'(rch); i_dmp_ch = 1'(dch); i_dmp_pos = 5'(dpos);
    #1;
  endtask

  initial begin
    int pw, pr;
    merr = '0;
    i_rst_n = 1'b0; i_clr = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    i_wr_ch = '0; i_rd_ch = '0; i_dmp_ch = '0; i_dmp_pos = '0; i_data = '0;
    #2 check_outs();
    #10 i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Three pushes to channel 0, then view head and dump window.
    step(1, 0, 8'h11, 0, 0, 0);
    step(1, 0, 8'h22, 0, 0, 0);
    step(1, 0, 8'h33, 0, 0, 0);
    peek(0, 0, 2);
    chk("r23_head", 32'(o_data), 32'h11);
    chk("r23_empty_n", 32'(o_empty_n), 32'b01);
    chk("r23_pos2_data", 32'(o_dmp_data), 32'h33);
    chk("r23_pos2_valid", 32'(o_dmp_valid), 32'd1);
    peek(0, 0, 3);
    chk("r23_pos3_valid", 32'(o_dmp_valid), 32'd0);
`ifdef HRM_IOBOX_FILL_EN
    chk("r23_fill", 32'(o_fill), 32'd3);
`endif

    // Overflow channel 1 and drain in order.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) step(1, 1, 8'(i), 0, 1, 0);
    step(1, 1, 8'hAA, 0, 1, 0);
    peek(1, 1, 31);
    chk("r24_full", 32'(o_full[1]), 32'd1);
    chk("r24_err", 32'(o_err[1]), 32'd1);
    chk("r24_last", 32'(o_dmp_data), 32'd31);
    for (int i = 0; i < 32; i++) begin
      peek(1, 1, 0);
      chk("r24_pop", 32'(o_data), 32'(i));
      step(0, 0, 0, 1, 1, 0);
    end
    peek(1, 1, 0);
    chk("r24_drained", 32'(o_empty_n[1]), 32'd0);

    // Same-cycle push and pop on a full channel.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) step(1, 0, 8'(i + 100), 0, 0, 0);
    step(1, 0, 8'h55, 1, 0, 0);
    peek(0, 0, 31);
    chk("r25_full", 32'(o_full[0]), 32'd1);
    chk("r25_err", 32'(o_err[0]), 32'd0);
    chk("r25_tail", 32'(o_dmp_data), 32'h55);
    for (int i = 0; i < 31; i++) step(0, 0, 0, 1, 0, 0);
    peek(0, 0, 0);
    chk("r25_head", 32'(o_data), 32'h55);

    // Same-cycle push and pop on an empty channel, then flush.
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 8'h7E, 1, 0, 0);
    peek(0, 0, 1);
    chk("r26_head", 32'(o_data), 32'h7E);
    chk("r26_err", 32'(o_err[0]), 32'd1);
    chk("r26_one", 32'(o_dmp_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    peek(0, 0, 0);
    chk("r26_clr_err", 32'(o_err), 32'd0);
    chk("r26_clr_empty", 32'(o_empty_n), 32'd0);

    // Repeated fill/drain of channel 0 across wrap, channel 1 undisturbed.
    step(1, 1, 8'h01, 0, 0, 0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 32; i++) step(1, 0, 8'($urandom), 0, 0, 0);
      for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 0, 0);
    end
    peek(1, 1, 0);
    chk("r27_head1", 32'(o_data), 32'h01);
    chk("r27_dmp1", 32'(o_dmp_data), 32'h01);
    chk("r27_dmp1_valid", 32'(o_dmp_valid), 32'd1);

    // Asynchronous reset in the middle of a burst.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(i + 1), 0, 0, 0);
    i_wr = 1'b1; i_wr_ch = 1'b0; i_data = 8'hEE;
    i_dmp_ch = 1'b0; i_dmp_pos = 5'd0; i_rd_ch = 1'b0;
    #2 i_rst_n = 1'b0;
    i_wr = 1'b0;
    #1;
    chk("r28_empty_n", 32'(o_empty_n), 32'd0);
    chk("r28_data", 32'(o_data), 32'd0);
    chk("r28_full", 32'(o_full), 32'd0);
    chk("r28_err", 32'(o_err), 32'd0);
    chk("r28_fill", 32'(o_fill), 32'd0);
    chk("r28_dmp_valid", 32'(o_dmp_valid), 32'd0);
    chk("r28_dmp_data", 32'(o_dmp_data), 32'd0);
    for (int c = 0; c < 2; c++) mq[c].delete();
    merr = '0;
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk); #1;
    peek(0, 0, 0);
    chk("r28_post_valid", 32'(o_dmp_valid), 32'd0);
    step(1, 0, 8'hC3, 0, 0, 0);
    peek(0, 0, 0);
    chk("r28_pos0", 32'(o_dmp_data), 32'hC3);
    chk("r28_head", 32'(o_data), 32'hC3);

    // Random traffic with shifting push/pop bias.
    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 50 : 20;
      pr = 100 - pw;
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 99) < pw), int'($urandom_range(0, 1)), 8'($urandom),
             ($urandom_range(0, 99) < pr), int'($urandom_range(0, 1)),
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hrm_iobox.md
HRM_IOBOX -- requirements
Module: hrm_iobox

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter LGFLEN, default 5, log2 of per-channel depth (DEPTH = 2**LGFLEN).
REQ-003 SHALL have parameter NCH, default 2, number of independent FIFO channels; CHW = max(1, clog2(NCH)).
REQ-004 SHALL have ports, in this order:
 clk  in  1  sole clock, rising edge.
 i_rst_n  in  1  asynchronous, active-low reset.
 i_clr  in  1  synchronous flush of all channels.
 i_wr  in  1  push strobe.
 i_wr_ch  in  CHW  push channel.
 i_data  in  WIDTH  push data.
 i_rd  in  1  pop strobe.
 i_rd_ch  in  CHW  pop/view channel.
 o_data  out  WIDTH  head word of i_rd_ch.
 o_empty_n  out  NCH  per-channel not-empty.
 o_full  out  NCH  per-channel full.
 o_err  out  NCH  per-channel sticky overflow/underflow.
 o_fill  out  LGFLEN+1  occupancy of i_rd_ch.
 i_dmp_ch  in  CHW  dump channel.
 i_dmp_pos  in  LGFLEN  dump position, 0 = oldest.
 o_dmp_data  out  WIDTH  word at dump position.
 o_dmp_valid  out  1  dump position holds data.

Function
REQ-005 Each channel SHALL be a circular buffer of DEPTH words with read/write pointers of LGFLEN bits that wrap from DEPTH-1 to 0 and a count of LGFLEN+1 bits.
REQ-006 Push on an accepted cycle SHALL store i_data at write pointer, advance pointer, count+1; visible on o_data/dump the next cycle.
REQ-007 Pop SHALL advance read pointer and count-1; o_data is first-word-fall-through, combinational from head of i_rd_ch, 0 when that channel is empty.
REQ-008 Push to a full channel SHALL be dropped, contents unchanged, o_err[ch] set.
REQ-009 Pop from an empty channel SHALL be ignored and set o_err[ch].
REQ-010 Push and pop to the same full channel in one cycle SHALL both succeed, count unchanged, no error.
REQ-011 Push and pop to the same empty channel in one cycle SHALL accept the push, ignore the pop, set o_err[ch]; count becomes 1.
REQ-012 Push and pop to different channels in one cycle SHALL proceed independently.
REQ-013 Channel indices >= NCH SHALL be ignored for push/pop (no state change, no error); dump returns o_dmp_valid=0, o_dmp_data=0.
REQ-014 o_empty_n[ch] = (count!=0), o_full[ch] = (count==DEPTH), both registered-state derived, no combinational path from strobes.
REQ-015 o_err bits SHALL remain set until reset or i_clr.
REQ-016 Dump SHALL be combinational: o_dmp_valid = (i_dmp_pos < count of i_dmp_ch); o_dmp_data = word at (rdptr + i_dmp_pos) mod DEPTH when valid, else 0.
REQ-017 i_clr SHALL zero all pointers, counts and o_err on the next edge, overriding i_wr/i_rd that cycle; memory contents need not clear.

Reset
REQ-018 On i_rst_n low, asynchronously: all pointers and counts 0, o_empty_n=0, o_full=0, o_err=0, o_fill=0, o_data=0, o_dmp_valid=0, o_dmp_data=0.
REQ-019 Reset asserted mid-operation SHALL discard all queued data; first edge after release with i_wr SHALL store at position 0.
REQ-020 Storage array SHALL NOT be reset.

Configuration
REQ-021 With macro HRM_IOBOX_FILL_EN defined, o_fill SHALL equal the count of channel i_rd_ch (0 for out-of-range index).
REQ-022 Without HRM_IOBOX_FILL_EN, o_fill SHALL be constant 0 and no fill mux logic SHALL be built; all other behaviour identical.

Verification
REQ-023 Reset, push 0x11,0x22,0x33 to ch0 -> o_data=0x11, o_empty_n=2'b01, dump pos2=0x33 valid, pos3 invalid, o_fill=3 (FILL_EN).
REQ-024 Push 32 words 0..31 to ch1, then push 0xAA -> o_full[1]=1, o_err[1]=1, pops return 0..31 in order, 0xAA never appears.
REQ-025 Ch0 full, same-cycle push 0x55 + pop -> count stays 32, o_err[0]=0, after 31 more pops o_data=0x55.
REQ-026 Ch0 empty, same-cycle push 0x7E + pop -> o_data=0x7E, count 1, o_err[0]=1; i_clr -> o_err=0, o_empty_n=0.
REQ-027 Fill/drain ch0 40 times across pointer wrap while ch1 holds 0x01 -> ch1 head stays 0x01, dump ch1 pos0=0x01.
REQ-028 Assert i_rst_n low asynchronously mid-burst with 5 words queued -> outputs zero immediately, no edge required; post-reset dump pos0 invalid.
